muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Multiplies with a 32-step shift-add on the operand magnitudes, divides with
// a 32-step restoring shift-subtract, then applies a sign correction when the
// result is presented. Divide-by-zero and signed overflow skip the iteration
// and complete one cycle after the request.
//
// Ports:
//   clock            system clock, rising edge
//   n_reset          asynchronous active-low reset
//   start            operation request, sampled only in IDLE
//   funct3           RV32M operation select
//   rs1_read_data    operand A
//   rs2_read_data    operand B
//   rd_in            destination register index of the request
//   busy             high whenever the unit is not IDLE
//   done             one-cycle pulse when the result is presented
//   rd_address       latched destination index
//   rd_write_enable  register file write strobe (suppressed for x0)
//   rd_write_data    result value, valid while done=1
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one shift-add / shift-subtract step per cycle, 32 steps
// DONE  | result presented for one cycle, write strobe issued

module muldiv_unit (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_read_data,
  input  logic [31:0] rs2_read_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_address,
  output logic        rd_write_enable,
  output logic [31:0] rd_write_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] m_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] p_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic        neg_q;    // selected result must be negated
  logic        byp_q;    // special case: result already in p_q[31:0]
  logic [4:0]  cnt_q;

  // request decode
  logic        is_div, div_signed, a_signed, b_signed, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_val;
  logic        neg_in;

  always_comb begin
    is_div     = funct3[2];
    div_signed = is_div & ~funct3[0];
    if (is_div) begin
      a_signed = div_signed;
      b_signed = div_signed;
    end else begin
      // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = ~funct3[1];
    end
    sa    = a_signed & rs1_read_data[31];
    sb    = b_signed & rs2_read_data[31];
    a_mag = sa ? (32'd0 - rs1_read_data) : rs1_read_data;
    b_mag = sb ? (32'd0 - rs2_read_data) : rs2_read_data;

    div_zero = is_div && (rs2_read_data == 32'd0);
    div_ovf  = div_signed && (rs1_read_data == 32'h8000_0000)
                          && (rs2_read_data == 32'hFFFF_FFFF);
    special  = div_zero | div_ovf;

    if (div_zero)
      special_val = funct3[1] ? rs1_read_data : 32'hFFFF_FFFF;
    else
      special_val = funct3[1] ? 32'd0 : 32'h8000_0000;

    // remainder follows the dividend sign, everything else the product sign
    if (is_div && funct3[1])
      neg_in = sa;
    else
      neg_in = sa ^ sb;
  end

  // one iteration step
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
    mul_next  = {mul_sum, p_q[31:1]};
    div_shift = {p_q[63:32], p_q[31]};
    div_diff  = div_shift - {1'b0, m_q};
    // restore when the trial subtraction borrows
    if (div_diff[32])
      div_next = {div_shift[31:0], p_q[30:0], 1'b0};
    else
      div_next = {div_diff[31:0], p_q[30:0], 1'b1};
  end

  // sign correction and result select
  logic [63:0] mul_full;
  logic [31:0] mul_res, div_raw, div_res, result;

  always_comb begin
    mul_full = neg_q ? (64'd0 - p_q) : p_q;
    mul_res  = (op_q[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];
    div_raw  = op_q[1] ? p_q[63:32] : p_q[31:0];
    div_res  = neg_q ? (32'd0 - div_raw) : div_raw;
    if (byp_q)
      result = p_q[31:0];
    else if (op_q[2])
      result = div_res;
    else
      result = mul_res;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = special ? DONE : CALC;
      CALC: if (cnt_q == 5'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      op_q  <= 3'd0;
      rd_q  <= 5'd0;
      m_q   <= 32'd0;
      p_q   <= 64'd0;
      neg_q <= 1'b0;
      byp_q <= 1'b0;
      cnt_q <= 5'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= funct3;
            rd_q  <= rd_in;
            neg_q <= neg_in;
            byp_q <= special;
            cnt_q <= 5'd0;
            if (special) begin
              m_q <= 32'd0;
              p_q <= {32'd0, special_val};
            end else if (is_div) begin
              m_q <= b_mag;
              p_q <= {32'd0, a_mag};
            end else begin
              m_q <= a_mag;
              p_q <= {32'd0, b_mag};
            end
          end
        end
        CALC: begin
          p_q   <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (state != IDLE);
    done            = (state == DONE);
    rd_address      = rd_q;
    rd_write_enable = (state == DONE) && (rd_q != 5'd0);
    rd_write_data   = (state == DONE) ? result : 32'd0;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_read_data;
  logic [31:0] rs2_read_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [4:0]  rd_address;
  logic        rd_write_enable;
  logic [31:0] rd_write_data;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_unit dut (
    .clock           (clock),
    .n_reset         (n_reset),
    .start           (start),
    .funct3          (funct3),
    .rs1_read_data   (rs1_read_data),
    .rs2_read_data   (rs2_read_data),
    .rd_in           (rd_in),
    .busy            (busy),
    .done            (done),
    .rd_address      (rd_address),
    .rd_write_enable (rd_write_enable),
    .rd_write_data   (rd_write_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, write port and the return to IDLE.
  // With noise set, start stays high with scrambled inputs for the whole
  // operation including the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input bit noise);
    int lat;
    @(negedge clock);
    start = 1'b1; funct3 = f; rs1_read_data = a; rs2_read_data = b; rd_in = rd;
    @(posedge clock); #1;
    lat = 1;
    if (noise) begin
      funct3 = ~f; rs1_read_data = $urandom; rs2_read_data = $urandom; rd_in = rd + 5'd3;
    end else begin
      start = 1'b0;
    end
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (noise) begin
        rs1_read_data = $urandom; rs2_read_data = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
    end
    check({tag, ".lat"},  lat, exp_lat);
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".data"}, rd_write_data, exp);
    check({tag, ".we"},   {31'd0, rd_write_enable}, {31'd0, rd != 5'd0});
    check({tag, ".addr"}, {27'd0, rd_address}, {27'd0, rd});
    @(posedge clock); #1;
    start = 1'b0;
    check({tag, ".done_low"}, {31'd0, done}, 32'd0);
    check({tag, ".we_low"},   {31'd0, rd_write_enable}, 32'd0);
    check({tag, ".idle"},     {31'd0, busy}, 32'd0);
  endtask

  int pulses;

  initial begin
    n_reset = 1'b0; start = 1'b0; funct3 = 3'd0;
    rs1_read_data = 32'd0; rs2_read_data = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.we",   {31'd0, rd_write_enable}, 32'd0);
    check("rst.addr", {27'd0, rd_address}, 32'd0);
    check("rst.data", rd_write_data, 32'd0);
    @(negedge clock); n_reset = 1'b1;

    run_op("mul",      F_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulh",     F_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 33, 1'b0);
    run_op("mulhu",    F_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h7FFF_FFFF, 33, 1'b0);
    run_op("mulhsu",   F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000, 33, 1'b0);
    run_op("mulhu_ff", F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33, 1'b0);
    run_op("div",      F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem",      F_REM,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_nd",   F_DIV,    32'd7,         32'hFFFF_FFFE, 5'd8,  32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_nd",   F_REM,    32'd7,         32'hFFFF_FFFE, 5'd9,  32'h0000_0001, 33, 1'b0);
    run_op("divu",     F_DIVU,   32'd100,       32'd7,         5'd10, 32'd14,        33, 1'b0);
    run_op("remu",     F_REMU,   32'd100,       32'd7,         5'd11, 32'd2,         33, 1'b0);
    run_op("divu_big", F_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd12, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu_z",   F_DIVU,   32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem_z",    F_REM,    32'h1234,      32'd0,         5'd14, 32'h1234,      1,  1'b0);
    run_op("div_z",    F_DIV,    32'd5,         32'd0,         5'd15, 32'hFFFF_FFFF, 1,  1'b0);
    run_op("remu_z",   F_REMU,   32'hDEAD_BEEF, 32'd0,         5'd16, 32'hDEAD_BEEF, 1,  1'b0);
    run_op("div_ovf",  F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1,  1'b0);
    run_op("rem_ovf",  F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1,  1'b0);
    run_op("noise",    F_MUL,    32'd7,         32'hFFFF_FFFD, 5'd19, 32'hFFFF_FFEB, 33, 1'b1);
    run_op("rd0",      F_MUL,    32'd3,         32'd4,         5'd0,  32'd12,        33, 1'b0);

    // reset in the middle of a divide
    @(negedge clock);
    start = 1'b1; funct3 = F_DIV; rs1_read_data = 32'd1000; rs2_read_data = 32'd3; rd_in = 5'd9;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    check("abort.busy_pre", {31'd0, busy}, 32'd1);
    n_reset = 1'b0;
    #1;
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.addr", {27'd0, rd_address}, 32'd0);
    check("abort.data", rd_write_data, 32'd0);
    repeat (2) @(negedge clock);
    n_reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (rd_write_enable || done) pulses++;
    end
    check("abort.no_we", pulses, 32'd0);
    check("abort.idle", {31'd0, busy}, 32'd0);

    run_op("post_rst", F_REMU, 32'd1000, 32'd3, 5'd20, 32'd1, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
